// File: rtl/ptfloat_unpack.sv
// ptfloat_unpack: splits a packed pt-float word into a sign-extended
// exponent and a left-aligned mantissa. Two register stages: the input
// word is captured in stage 1, the decoded fields land in stage 2.
module ptfloat_unpack #(
    parameter int DATA_W    = 32,
    parameter int EW_W      = 4,
    localparam int EXP_MAX_W = (2 ** EW_W) - 1,
    localparam int MAN_MAX_W = DATA_W - EW_W
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 cke_i,
    input  logic                 start_i,
    output logic                 done_o,
    input  logic [DATA_W-1:0]    data_i,
    output logic [EXP_MAX_W-1:0] exp_o,
    output logic [MAN_MAX_W-1:0] man_o
);

    // Width of the exponent+mantissa remainder below the EW field.
    localparam int R = DATA_W - EW_W;

    // The mantissa must keep at least one bit even at the widest exponent.
    if (EXP_MAX_W >= MAN_MAX_W) begin : g_param_check
        $error("ptfloat_unpack: EXP_MAX_W must be smaller than MAN_MAX_W");
    end

    // Exponent: top w bits of the remainder, sign-extended. An arithmetic
    // right shift by R-w both extracts and sign-extends the field; w=0 is
    // forced to zero since there is no field to take a sign from.
    function automatic logic [EXP_MAX_W-1:0] decode_exp(input logic [DATA_W-1:0] d);
        logic [EW_W-1:0]   w;
        logic signed [R-1:0] f;
        logic signed [R-1:0] sh;
        w  = d[DATA_W-1 -: EW_W];
        f  = d[R-1:0];
        sh = f >>> (R - int'(w));
        if (w == '0) begin
            return '0;
        end
        return sh[EXP_MAX_W-1:0];
    endfunction

    // Mantissa: shifting the whole remainder left by w drops the exponent
    // field off the top and leaves the mantissa MSB-aligned.
    function automatic logic [MAN_MAX_W-1:0] decode_man(input logic [DATA_W-1:0] d);
        logic [EW_W-1:0] w;
        w = d[DATA_W-1 -: EW_W];
        return d[R-1:0] << w;
    endfunction

    logic [DATA_W-1:0]    data_q, data_d;
    logic                 vld_q,  vld_d;
    logic [EXP_MAX_W-1:0] exp_q,  exp_d;
    logic [MAN_MAX_W-1:0] man_q,  man_d;
    logic                 done_q, done_d;

    // Next-state for both stages; everything holds while cke_i is low.
    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        exp_d  = exp_q;
        man_d  = man_q;
        done_d = done_q;
        if (cke_i) begin
            // Stage 1: capture the word on start, valid follows start.
            vld_d = start_i;
            if (start_i) begin
                data_d = data_i;
            end
            // Stage 2: decode the captured word; results only move on valid.
            done_d = vld_q;
            if (vld_q) begin
                exp_d = decode_exp(data_q);
                man_d = decode_man(data_q);
            end
        end
    end

    // State registers with synchronous active-low reset taking priority.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            data_q <= '0;
            vld_q  <= 1'b0;
            exp_q  <= '0;
            man_q  <= '0;
            done_q <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
            exp_q  <= exp_d;
            man_q  <= man_d;
            done_q <= done_d;
        end
    end

    assign done_o = done_q;
    assign exp_o  = exp_q;
    assign man_o  = man_q;

endmodule

// File: tb/tb_ptfloat_unpack.sv
// Directed testbench for ptfloat_unpack with hand-computed expectations.
module tb_ptfloat_unpack;

    localparam int DATA_W    = 32;
    localparam int EW_W      = 4;
    localparam int EXP_MAX_W = 15;
    localparam int MAN_MAX_W = 28;

    logic                 clk_i;
    logic                 rst_n_i;
    logic                 cke_i;
    logic                 start_i;
    logic                 done_o;
    logic [DATA_W-1:0]    data_i;
    logic [EXP_MAX_W-1:0] exp_o;
    logic [MAN_MAX_W-1:0] man_o;

    int errors = 0;
    int checks = 0;

    ptfloat_unpack #(.DATA_W(DATA_W), .EW_W(EW_W)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .cke_i   (cke_i),
        .start_i (start_i),
        .done_o  (done_o),
        .data_i  (data_i),
        .exp_o   (exp_o),
        .man_o   (man_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance one rising edge, then settle 1 ns before sampling or driving.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic e_done,
                       input logic [EXP_MAX_W-1:0] e_exp,
                       input logic [MAN_MAX_W-1:0] e_man);
        checks++;
        assert (done_o === e_done) else begin
            errors++;
            $error("FAIL %s done: got %0b expected %0b", tag, done_o, e_done);
        end
        checks++;
        assert (exp_o === e_exp) else begin
            errors++;
            $error("FAIL %s exp: got %h expected %h", tag, exp_o, e_exp);
        end
        checks++;
        assert (man_o === e_man) else begin
            errors++;
            $error("FAIL %s man: got %h expected %h", tag, man_o, e_man);
        end
    endtask

    initial begin
        rst_n_i = 1'b0;
        cke_i   = 1'b1;
        start_i = 1'b1;
        data_i  = 32'hDEADBEEF;

        // Reset held with start asserted: everything stays zero.
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("reset_hold", 1'b0, 15'h0000, 28'h0000000);
        end

        // First start after release, then back-to-back starts.
        rst_n_i = 1'b1;
        data_i  = 32'h0000000F;
        tick();
        chk("b2b_e0", 1'b0, 15'h0000, 28'h0000000);
        data_i  = 32'h0002000F;
        tick();
        chk("b2b_r0", 1'b1, 15'h0000, 28'h000000F);
        data_i  = 32'h80000000;
        tick();
        chk("b2b_r1", 1'b1, 15'h0000, 28'h002000F);
        start_i = 1'b0;
        data_i  = 32'h0;
        tick();
        chk("b2b_r2", 1'b1, 15'h0000, 28'h0000000);
        tick();
        chk("b2b_idle", 1'b0, 15'h0000, 28'h0000000);

        // Mantissa alignment for w = 12, 10, 6.
        start_i = 1'b1;
        data_i  = 32'hC0000001;
        tick();
        chk("al_e0", 1'b0, 15'h0000, 28'h0000000);
        data_i  = 32'hA0000002;
        tick();
        chk("al_w12", 1'b1, 15'h0000, 28'h0001000);
        data_i  = 32'h60000002;
        tick();
        chk("al_w10", 1'b1, 15'h0000, 28'h0000800);
        start_i = 1'b0;
        tick();
        chk("al_w6", 1'b1, 15'h0000, 28'h0000080);
        tick();
        chk("al_idle", 1'b0, 15'h0000, 28'h0000080);

        // Negative and wide exponents.
        start_i = 1'b1;
        data_i  = 32'h4F000000;
        tick();
        chk("ex_e0", 1'b0, 15'h0000, 28'h0000080);
        data_i  = 32'hF0008000;
        tick();
        chk("ex_neg1", 1'b1, 15'h7FFF, 28'h0000000);
        data_i  = 32'h17FFFFFF;
        tick();
        chk("ex_w15", 1'b1, 15'h0004, 28'h0000000);
        start_i = 1'b0;
        tick();
        chk("ex_w1", 1'b1, 15'h0000, 28'hFFFFFFE);
        tick();
        chk("ex_idle", 1'b0, 15'h0000, 28'hFFFFFFE);

        // Clock enable low for three edges freezes the pipeline.
        start_i = 1'b1;
        data_i  = 32'h60000002;
        tick();
        chk("cke_k", 1'b0, 15'h0000, 28'hFFFFFFE);
        start_i = 1'b0;
        data_i  = 32'h4F000000;
        cke_i   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("cke_frozen", 1'b0, 15'h0000, 28'hFFFFFFE);
        end
        cke_i = 1'b1;
        tick();
        chk("cke_result", 1'b1, 15'h0000, 28'h0000080);
        tick();
        chk("cke_idle", 1'b0, 15'h0000, 28'h0000080);
        // A done pulse must also freeze high while cke is low.
        start_i = 1'b1;
        data_i  = 32'hF0008000;
        tick();
        start_i = 1'b0;
        tick();
        chk("cke_pulse", 1'b1, 15'h0004, 28'h0000000);
        cke_i = 1'b0;
        tick();
        chk("cke_hold_hi", 1'b1, 15'h0004, 28'h0000000);
        cke_i = 1'b1;
        tick();
        chk("cke_fall", 1'b0, 15'h0004, 28'h0000000);

        // Reset mid-operation discards the in-flight word.
        start_i = 1'b1;
        data_i  = 32'hC0000001;
        tick();
        chk("rst_k", 1'b0, 15'h0004, 28'h0000000);
        start_i = 1'b0;
        rst_n_i = 1'b0;
        tick();
        chk("rst_k1", 1'b0, 15'h0000, 28'h0000000);
        rst_n_i = 1'b1;
        tick();
        chk("rst_k2", 1'b0, 15'h0000, 28'h0000000);
        tick();
        chk("rst_k3", 1'b0, 15'h0000, 28'h0000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ptfloat_unpack.md
Name: ptfloat_unpack

Overview:
- Unpacks a packed pt-float word into separate exponent and mantissa fields for downstream float arithmetic.
- The packed word has three fields:
  - a leading EW field of EW_W bits, holding the exponent width w;
  - a w-bit two's-complement exponent;
  - the remaining bits, a two's-complement mantissa.
- Outputs are fixed-width: the exponent is sign-extended and the mantissa is left-aligned.
- Fixed 2-cycle latency, start/done handshake, fully pipelined.

Parameters:
- DATA_W, 32, packed word width.
- EW_W, 4, width of the exponent-width field.
- EXP_MAX_W, 2**EW_W-1 (15), exp_o width (derived, not overridable).
- MAN_MAX_W, DATA_W-EW_W (28), man_o width (derived, not overridable).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_n_i  in  1  reset; synchronous, active-low.
- cke_i  in  1  clock enable; 0 freezes all registers.
- start_i  in  1  data_i valid; sampled each enabled edge.
- done_o  out  1  one-cycle pulse: exp_o/man_o hold a new result.
- data_i  in  DATA_W  packed word.
- exp_o  out  EXP_MAX_W  sign-extended exponent.
- man_o  out  MAN_MAX_W  left-aligned mantissa.

Behaviour:
- Reset:
  - rst_n_i=0 at a rising edge clears every register: stage-1 data/valid, exp_o, man_o, done_o all 0.
  - Reset has priority over cke_i; a reset mid-operation discards any in-flight result.
- cke_i=0: no register changes (done_o holds its value).
- Stage 1:
  - On an enabled edge with start_i=1, data_i is registered and the valid bit is set.
  - With start_i=0 the valid bit clears and the data register holds.
- Stage 2, on the next enabled edge:
  - Compute from the registered word; exp_o/man_o update only if valid=1, otherwise they hold.
  - done_o <= valid.
- Latency: start at edge k gives results and done_o=1 after edge k+1; done_o falls after edge k+2 unless another start occurred at k+1.
- Back-to-back starts are accepted every cycle; there is no stall or backpressure.
- Decode, with R = DATA_W-EW_W:
  - w = data[DATA_W-1 -: EW_W], unsigned, range 0..2**EW_W-1.
  - Exponent field = data[R-1 -: w]; w=0 gives an exponent of 0.
  - exp_o = that field sign-extended (bit R-1 is the sign when w>0) to EXP_MAX_W.
  - man_o = data[R-w-1:0] << w, i.e. the mantissa MSB sits at man_o[MAN_MAX_W-1] and the low w bits are zero.
  - Equivalent form: man_o = data[R-1:0] << w, truncated to MAN_MAX_W.
- Parameter constraint: EXP_MAX_W < MAN_MAX_W is required (checked at elaboration), so the mantissa always has at least 1 bit.
- No illegal EW encodings exist; every w value is decoded.
- Implementation is combinational shift/sign-extend logic between the two register stages; no multi-cycle FSM.

Test Plan:
- Hold rst_n_i=0 for 100 cycles with start_i=1 -> done_o=0, exp_o=0, man_o=0 throughout; first start after release -> done_o after 2 edges.
- Consecutive starts with data_i = 0x0000000F, 0x0002000F, 0x80000000 -> 2 cycles later done_o stays high 3 cycles, giving (exp,man) = (0,0x000000F), (0,0x002000F), (0,0x0000000).
- data_i = 0xC0000001, 0xA0000002, 0x60000002 (w = 12, 10, 6) -> man_o = 0x0001000, 0x0000800, 0x0000080; exp_o = 0.
- Negative/wide exponents:
  - 0x4F000000 (w=4, field 0xF) -> exp_o=0x7FFF (-1), man_o=0.
  - 0xF0008000 (w=15) -> exp_o=4, man_o=0.
  - 0x17FFFFFF (w=1, field 0) -> exp_o=0, man_o=0xFFFFFFE.
- Clock enable: start at edge k, cke_i=0 for edges k+1..k+3 -> outputs and done_o frozen; result appears one enabled edge later.
- Reset mid-operation: start at edge k, rst_n_i=0 at edge k+1 -> done_o never pulses; outputs are 0.
